mips_mem_responder: RTL and testbench

MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

---
 rtl/mips_mem_pkg.sv | 26 ++
 rtl/mips_mem_array.sv | 35 +++
 rtl/mips_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_mips_mem_responder.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg
//   Shared types and defaults for the MIPS memory responder slice.
//   byte_lane_t : one 8-bit byte lane
//   word_t      : four byte lanes, lane 0 is the most significant byte
//   state_e     : responder FSM states
//   addr_out_of_range() : misaligned or beyond the 2^ADDR_BITS word window
package mips_mem_pkg;

   localparam int unsigned DEFAULT_ADDR_BITS = 10;
   localparam int unsigned DEFAULT_LATENCY   = 2;

   typedef logic [7:0] byte_lane_t;
   typedef byte_lane_t [0:3] word_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_e;

   function automatic logic addr_out_of_range(input logic [31:0] addr,
                                              input int unsigned addr_bits);
      return (addr[1:0] != 2'b00) || ((addr >> (addr_bits + 2)) != 32'd0);
   endfunction

endpackage

// File: rtl/mips_mem_array.sv
// mips_mem_array
//   Word-wide storage: 2^ADDR_BITS words, one synchronous write port and
//   one combinational read port. Contents are never reset.
//   clk      : write clock
//   wr_en    : commit wr_data to wr_idx at posedge
//   wr_idx   : write word index
//   wr_data  : write word
//   rd_idx   : read word index
//   rd_data  : word currently stored at rd_idx
module mips_mem_array
   import mips_mem_pkg::*;
#(
   parameter int unsigned ADDR_BITS = DEFAULT_ADDR_BITS
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic [ADDR_BITS-1:0] wr_idx,
   input  word_t                wr_data,
   input  logic [ADDR_BITS-1:0] rd_idx,
   output word_t                rd_data
);

   word_t mem [2**ADDR_BITS];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   always_comb begin
      rd_data = mem[rd_idx];
   end

endmodule

// File: rtl/mips_mem_responder.sv
// mips_mem_responder
//   Fixed-latency memory responder for a MIPS core. A request is captured
//   in IDLE, held in WAIT for LATENCY-1 cycles, and completed with a
//   one-cycle mem_ready pulse in RESP. Writes commit at the edge ending
//   RESP; read data is registered on entry to RESP and held until the next
//   successful read.
//   Optional feature macro: MIPS_MEM_ERR_EN -- misaligned or out-of-window
//   addresses complete with mem_err=1 and have no side effects. Without it
//   mem_err is 0 and the address wraps onto the word window.
//   clk, rst      : clock, synchronous active-high reset
//   mem_req       : request valid, held until mem_ready
//   mem_addr      : byte address
//   mem_write_en  : 1 = write, 0 = read
//   mem_data_in   : write data, lane 0 = MSB
//   mem_data_out  : read data, lane 0 = MSB
//   mem_ready     : completion pulse
//   mem_err       : error flag, qualified by mem_ready
module mips_mem_responder
   import mips_mem_pkg::*;
#(
   parameter int unsigned ADDR_BITS = DEFAULT_ADDR_BITS,
   parameter int unsigned LATENCY   = DEFAULT_LATENCY
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_req,
   input  logic [31:0]      mem_addr,
   input  logic             mem_write_en,
   input  byte_lane_t [0:3] mem_data_in,
   output byte_lane_t [0:3] mem_data_out,
   output logic             mem_ready,
   output logic             mem_err
);

   localparam logic [3:0] WAIT_CYCLES = 4'(LATENCY - 1);

   state_e               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   word_t                rdata_q, rdata_d;
   logic [ADDR_BITS-1:0] idx_q, idx_d;
   logic                 we_q, we_d;
   logic                 bad_q, bad_d;
   word_t                wdata_q, wdata_d;

   logic [ADDR_BITS-1:0] req_idx;
   logic [ADDR_BITS-1:0] rd_idx;
   logic                 req_bad;
   logic                 arr_we;
   logic                 load_rd;
   word_t                arr_rdata;

   always_comb begin
      req_idx = mem_addr[ADDR_BITS+1:2];
`ifdef MIPS_MEM_ERR_EN
      req_bad = addr_out_of_range(mem_addr, ADDR_BITS);
`else
      req_bad = 1'b0;
`endif
   end

`ifndef MIPS_MEM_ERR_EN
   logic unused_addr_bits;
   always_comb begin
      unused_addr_bits = ^{mem_addr[31:ADDR_BITS+2], mem_addr[1:0]};
   end
`endif

   // With LATENCY=1 the read happens on the capture edge, so the array is
   // addressed from the live bus in IDLE and from the latched index after.
   always_comb begin
      rd_idx = (state_q == ST_IDLE) ? req_idx : idx_q;
      // A reset on the edge ending RESP aborts the write.
      arr_we = (state_q == ST_RESP) && we_q && !bad_q && !rst;
   end

   mips_mem_array #(
      .ADDR_BITS(ADDR_BITS)
   ) u_array (
      .clk     (clk),
      .wr_en   (arr_we),
      .wr_idx  (idx_q),
      .wr_data (wdata_q),
      .rd_idx  (rd_idx),
      .rd_data (arr_rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      we_d    = we_q;
      bad_d   = bad_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      load_rd = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (mem_req) begin
               idx_d   = req_idx;
               we_d    = mem_write_en;
               bad_d   = req_bad;
               wdata_d = mem_data_in;
               if (WAIT_CYCLES == 4'd0) begin
                  state_d = ST_RESP;
                  load_rd = !mem_write_en && !req_bad;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_CYCLES;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q <= 4'd1) begin
               state_d = ST_RESP;
               cnt_d   = '0;
               load_rd = !we_q && !bad_q;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (load_rd) begin
         rdata_d = arr_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      idx_q   <= idx_d;
      we_q    <= we_d;
      bad_q   <= bad_d;
      wdata_q <= wdata_d;
   end

   always_comb begin
      mem_data_out = rdata_q;
      mem_ready    = (state_q == ST_RESP);
`ifdef MIPS_MEM_ERR_EN
      mem_err      = (state_q == ST_RESP) && bad_q;
`else
      mem_err      = 1'b0;
`endif
   end

endmodule

// File: tb/tb_mips_mem_responder.sv
// tb_mips_mem_responder
//   Bench for mips_mem_responder: dut 0 runs LATENCY=2, dut 1 LATENCY=1.
//   A reference word store keyed by (dut, index) produces the expected
//   completion for every request; expectations are queued when a request
//   is driven and popped when mem_ready is observed.
module tb_mips_mem_responder;
   import mips_mem_pkg::*;

`ifdef MIPS_MEM_ERR_EN
   localparam int unsigned AB = 12;
`else
   localparam int unsigned AB = 10;
`endif

   typedef struct packed {
      logic       seen;
      logic [3:0] lat;
      logic       err;
      word_t      data;
   } txn_t;

   typedef struct {
      logic [31:0] a;
      logic        w;
      word_t       d;
   } req_t;

   logic        clk;
   logic        rst;
   logic        req  [2];
   logic [31:0] addr [2];
   logic        we   [2];
   word_t       din  [2];
   word_t       dout [2];
   logic        rdy  [2];
   logic        err  [2];

   int          lat_of [2] = '{2, 1};
   int          n_tests = 0;
   int          n_fail  = 0;
   txn_t        exp_q [$];
   word_t       model [int];
   word_t       exp_out [2];

   mips_mem_responder #(.ADDR_BITS(AB), .LATENCY(2)) u_dut0 (
      .clk(clk), .rst(rst), .mem_req(req[0]), .mem_addr(addr[0]),
      .mem_write_en(we[0]), .mem_data_in(din[0]), .mem_data_out(dout[0]),
      .mem_ready(rdy[0]), .mem_err(err[0])
   );

   mips_mem_responder #(.ADDR_BITS(AB), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst), .mem_req(req[1]), .mem_addr(addr[1]),
      .mem_write_en(we[1]), .mem_data_in(din[1]), .mem_data_out(dout[1]),
      .mem_ready(rdy[1]), .mem_err(err[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int key(input int s, input logic [31:0] a);
      return s * (1 << 20) + int'((a >> 2) & ((32'd1 << AB) - 32'd1));
   endfunction

   function automatic logic is_err(input logic [31:0] a);
`ifdef MIPS_MEM_ERR_EN
      return (a[1:0] != 2'b00) || ((a >> (AB + 2)) != 32'd0);
`else
      return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
   endfunction

   // Queues the expected completion, drives one request and waits (bounded)
   // for mem_ready. With chg set, address and data are disturbed after the
   // capture edge.
   task automatic issue(input int s, input logic [31:0] a, input logic w,
                        input word_t d, input logic chg, output txn_t got);
      txn_t e;
      logic er;
      er     = is_err(a);
      e.seen = 1'b1;
      e.lat  = 4'(lat_of[s]);
      e.err  = er;
      if (!er && w) model[key(s, a)] = d;
      if (!er && !w) exp_out[s] = model.exists(key(s, a)) ? model[key(s, a)] : '0;
      e.data = exp_out[s];
      exp_q.push_back(e);

      @(negedge clk);
      req[s] = 1'b1; addr[s] = a; we[s] = w; din[s] = d;
      got = '0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (chg) begin
            addr[s] = a ^ 32'h4;
            din[s]  = ~d;
         end
         if (rdy[s]) begin
            got.seen = 1'b1;
            got.lat  = 4'(i);
            got.err  = err[s];
            got.data = dout[s];
            break;
         end
      end
      req[s] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int s = 0; s < 2; s++) begin
         req[s] = 1'b0; addr[s] = '0; we[s] = 1'b0; din[s] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         n_tests++;
         if ({rdy[s], err[s], dout[s]} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_state[%0d]: got rdy=%b err=%b data=%h, want 0 0 00000000",
                     s, rdy[s], err[s], dout[s]);
         end
      end
      rst = 1'b0;
      exp_out[0] = '0;
      exp_out[1] = '0;
   endtask

   task automatic test_write_read();
      req_t tbl [4];
      txn_t got, e;
      tbl = '{'{32'h1000, 1'b1, 32'hDEADBEEF}, '{32'h1000, 1'b0, 32'h0},
              '{32'h0020, 1'b1, 32'h01234567}, '{32'h0020, 1'b0, 32'h0}};
      foreach (tbl[i]) begin
         issue(0, tbl[i].a, tbl[i].w, tbl[i].d, 1'b0, got);
         e = exp_q.pop_front();
         n_tests++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL write_read[%0d]: got rdy=%b lat=%0d err=%b data=%h, want rdy=%b lat=%0d err=%b data=%h",
                     i, got.seen, got.lat, got.err, got.data, e.seen, e.lat, e.err, e.data);
         end
      end
      n_tests++;
      if (got.data[0] !== 8'hDE && got.data[0] !== 8'h01) begin
         n_fail++;
         $display("FAIL lane0_msb: got %h, want 01", got.data[0]);
      end
   endtask

   task automatic test_back_to_back();
      req_t  tbl [3];
      txn_t  got, e;
      int    pulses, last, want_i;
      tbl = '{'{32'h10, 1'b1, 32'h10101010}, '{32'h14, 1'b1, 32'h14141414},
              '{32'h18, 1'b1, 32'h18181818}};
      foreach (tbl[i]) begin
         issue(0, tbl[i].a, tbl[i].w, tbl[i].d, 1'b0, got);
         e = exp_q.pop_front();
         n_tests++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL b2b_prep[%0d]: got rdy=%b lat=%0d err=%b, want rdy=%b lat=%0d err=%b",
                     i, got.seen, got.lat, got.err, e.seen, e.lat, e.err);
         end
      end
      for (int i = 0; i < 3; i++) begin
         e.seen = 1'b1; e.lat = 4'd2; e.err = 1'b0;
         e.data = model[key(0, tbl[i].a)];
         exp_q.push_back(e);
      end
      exp_out[0] = model[key(0, tbl[2].a)];

      @(negedge clk);
      req[0] = 1'b1; addr[0] = tbl[0].a; we[0] = 1'b0;
      pulses = 0; last = 0;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         if (rdy[0]) begin
            want_i = (pulses == 0) ? 2 : last + 3;
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL b2b_extra: got pulse at cycle %0d, want none", i);
            end else begin
               e = exp_q.pop_front();
               if (i !== want_i || err[0] !== e.err || dout[0] !== e.data) begin
                  n_fail++;
                  $display("FAIL b2b_pulse[%0d]: got cycle=%0d err=%b data=%h, want cycle=%0d err=%b data=%h",
                           pulses, i, err[0], dout[0], want_i, e.err, e.data);
               end
            end
            last = i;
            pulses++;
            if (pulses < 3) addr[0] = tbl[pulses].a;
            else req[0] = 1'b0;
         end
      end
      req[0] = 1'b0;
      n_tests++;
      if (pulses !== 3) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d pulses, want 3", pulses);
      end
   endtask

   task automatic test_addr_map();
      req_t tbl [3];
      txn_t got, e;
`ifdef MIPS_MEM_ERR_EN
      tbl = '{'{32'h1002, 1'b1, 32'h99999999}, '{32'h1000, 1'b0, 32'h0},
              '{32'h40000, 1'b0, 32'h0}};
`else
      tbl = '{'{32'h1004, 1'b1, 32'h00000011}, '{32'h0004, 1'b0, 32'h0},
              '{32'h0007, 1'b0, 32'h0}};
`endif
      foreach (tbl[i]) begin
         issue(0, tbl[i].a, tbl[i].w, tbl[i].d, 1'b0, got);
         e = exp_q.pop_front();
         n_tests++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL addr_map[%0d]: got rdy=%b lat=%0d err=%b data=%h, want rdy=%b lat=%0d err=%b data=%h",
                     i, got.seen, got.lat, got.err, got.data, e.seen, e.lat, e.err, e.data);
         end
      end
`ifndef MIPS_MEM_ERR_EN
      n_tests++;
      if (got.data[3] !== 8'h11) begin
         n_fail++;
         $display("FAIL wrap_lane3: got %h, want 11", got.data[3]);
      end
`endif
   endtask

   task automatic test_reset_abort();
      txn_t got, e;
      int   pulses;
      // Reset while dut 0 sits in WAIT of a write.
      @(negedge clk);
      req[0] = 1'b1; addr[0] = 32'h20; we[0] = 1'b1; din[0] = 32'hCAFEBABE;
      @(negedge clk);
      rst = 1'b1; req[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_out[0] = '0; exp_out[1] = '0;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (rdy[0]) pulses++;
      end
      n_tests++;
      if (pulses !== 0 || dout[0] !== 32'h0) begin
         n_fail++;
         $display("FAIL abort_wait: got pulses=%0d data=%h, want 0 00000000", pulses, dout[0]);
      end
      issue(0, 32'h20, 1'b0, '0, 1'b0, got);
      e = exp_q.pop_front();
      n_tests++;
      if (got !== e) begin
         n_fail++;
         $display("FAIL abort_wait_read: got rdy=%b lat=%0d data=%h, want rdy=%b lat=%0d data=%h",
                  got.seen, got.lat, got.data, e.seen, e.lat, e.data);
      end

      // Reset on the edge ending RESP of a dut 1 write.
      issue(1, 32'h60, 1'b1, 32'h77777777, 1'b0, got);
      e = exp_q.pop_front();
      n_tests++;
      if (got !== e) begin
         n_fail++;
         $display("FAIL abort_resp_prep: got rdy=%b lat=%0d, want rdy=%b lat=%0d",
                  got.seen, got.lat, e.seen, e.lat);
      end
      @(negedge clk);
      req[1] = 1'b1; addr[1] = 32'h60; we[1] = 1'b1; din[1] = 32'h88888888;
      @(negedge clk);
      n_tests++;
      if (rdy[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_resp_state: got rdy=%b, want 1", rdy[1]);
      end
      rst = 1'b1; req[1] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_out[0] = '0; exp_out[1] = '0;
      n_tests++;
      if (rdy[1] !== 1'b0 || dout[1] !== 32'h0) begin
         n_fail++;
         $display("FAIL abort_resp_out: got rdy=%b data=%h, want 0 00000000", rdy[1], dout[1]);
      end
      issue(1, 32'h60, 1'b0, '0, 1'b0, got);
      e = exp_q.pop_front();
      n_tests++;
      if (got !== e) begin
         n_fail++;
         $display("FAIL abort_resp_read: got rdy=%b lat=%0d data=%h, want rdy=%b lat=%0d data=%h",
                  got.seen, got.lat, got.data, e.seen, e.lat, e.data);
      end
   endtask

   task automatic test_capture_stability();
      req_t tbl [4];
      txn_t got, e;
      // dut 1 (LATENCY=1) and dut 0 (LATENCY=2), bus disturbed after capture.
      tbl = '{'{32'h40, 1'b1, 32'hA5A5A5A5}, '{32'h44, 1'b1, 32'h5A5A5A5A},
              '{32'h40, 1'b0, 32'h0}, '{32'h44, 1'b0, 32'h0}};
      foreach (tbl[i]) begin
         issue(1, tbl[i].a, tbl[i].w, tbl[i].d, 1'b1, got);
         e = exp_q.pop_front();
         n_tests++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL lat1[%0d]: got rdy=%b lat=%0d err=%b data=%h, want rdy=%b lat=%0d err=%b data=%h",
                     i, got.seen, got.lat, got.err, got.data, e.seen, e.lat, e.err, e.data);
         end
      end
      @(negedge clk);
      n_tests++;
      if (rdy[1] !== 1'b0 || dout[1] !== exp_out[1]) begin
         n_fail++;
         $display("FAIL lat1_hold: got rdy=%b data=%h, want 0 %h", rdy[1], dout[1], exp_out[1]);
      end

      tbl = '{'{32'h4C, 1'b1, 32'h55667788}, '{32'h48, 1'b1, 32'h11223344},
              '{32'h48, 1'b0, 32'h0}, '{32'h4C, 1'b0, 32'h0}};
      foreach (tbl[i]) begin
         issue(0, tbl[i].a, tbl[i].w, tbl[i].d, 1'b1, got);
         e = exp_q.pop_front();
         n_tests++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL lat2_stable[%0d]: got rdy=%b lat=%0d err=%b data=%h, want rdy=%b lat=%0d err=%b data=%h",
                     i, got.seen, got.lat, got.err, got.data, e.seen, e.lat, e.err, e.data);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_addr_map();
      test_reset_abort();
      test_capture_stability();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
